// File: rtl/udp_tx_sched_if.sv
// Scheduler <-> udp_tx datapath link: start strobes, payload length and byte stream.
interface udp_tx_sched_if;
    logic        tx_start_en;
    logic        state_change;
    logic [15:0] tx_byte_num;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_done;

    modport master (
        output tx_start_en, state_change, tx_byte_num, tx_data,
        input  tx_req, tx_done
    );

    modport slave (
        input  tx_start_en, state_change, tx_byte_num, tx_data,
        output tx_req, tx_done
    );
endinterface

// File: rtl/udp_tx_sched.sv
// Round-robin frame scheduler sharing one UDP transmit datapath between two packet sources.
//   state | meaning
//   IDLE  | waiting for a request; arbitrates round-robin
//   START | start strobes high for START_HOLD cycles
//   BUSY  | granted source streams bytes until tx_done or timeout
//   GAP   | inter-frame gap of IFG_CYCLES cycles
module udp_tx_sched #(
    parameter int START_HOLD     = 4,
    parameter int IFG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_BYTES      = 1472
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ch0_req,
    input  logic [15:0]           ch0_byte_num,
    output logic                  ch0_grant,
    output logic                  ch0_rd_en,
    input  logic [7:0]            ch0_rd_data,
    output logic                  ch0_done,
    input  logic                  ch1_req,
    input  logic [15:0]           ch1_byte_num,
    output logic                  ch1_grant,
    output logic                  ch1_rd_en,
    input  logic [7:0]            ch1_rd_data,
    output logic                  ch1_done,
    udp_tx_sched_if.master        dp,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [15:0]           frame_cnt
);

    localparam logic [15:0] HOLD_LOAD = 16'(START_HOLD - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        BUSY  = 4'b0100,
        GAP   = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic [15:0] byte_q, byte_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        seen_q, seen_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        terr_q, terr_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        pick;
    logic [15:0] pick_bytes;
    logic        in_frame;
    logic        finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            byte_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            seen_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            terr_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            terr_q  <= terr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        byte_d     = byte_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        seen_d     = seen_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        terr_d     = 1'b0;
        fcnt_d     = fcnt_q;
        finish     = 1'b0;
        pick       = (ch0_req && ch1_req) ? ~last_q : ch1_req;
        pick_bytes = pick ? ch1_byte_num : ch0_byte_num;

        case (state_q)
            IDLE: begin
                if (ch0_req || ch1_req) begin
                    sel_d  = pick;
                    last_d = pick;
                    byte_d = (pick_bytes > MAX_LEN) ? MAX_LEN : pick_bytes;
                    if (pick_bytes == 16'd0) begin
                        // empty frame: report completion without touching the datapath
                        done0_d = ~pick;
                        done1_d = pick;
                        cnt_d   = GAP_LOAD;
                        state_d = GAP;
                    end else begin
                        cnt_d   = HOLD_LOAD;
                        tmo_d   = TMO_LOAD;
                        seen_d  = 1'b0;
                        state_d = START;
                    end
                end
            end
            START: begin
                tmo_d = tmo_q - 16'd1;
                if (dp.tx_done) seen_d = 1'b1;
                if (cnt_q == 16'd0) state_d = BUSY;
                else                cnt_d   = cnt_q - 16'd1;
            end
            BUSY: begin
                if (dp.tx_done || seen_q) begin
                    finish = 1'b1;
                    fcnt_d = fcnt_q + 16'd1;
                end else if (tmo_q == 16'd0) begin
                    finish = 1'b1;
                    terr_d = 1'b1;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
                if (finish) begin
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == 16'd0) state_d = IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_frame        = (state_q == START) || (state_q == BUSY);
    assign ch0_grant       = in_frame & ~sel_q;
    assign ch1_grant       = in_frame & sel_q;
    assign ch0_rd_en       = dp.tx_req & ch0_grant;
    assign ch1_rd_en       = dp.tx_req & ch1_grant;
    assign ch0_done        = done0_q;
    assign ch1_done        = done1_q;
    assign dp.tx_start_en  = (state_q == START);
    assign dp.state_change = (state_q == START);
    assign dp.tx_byte_num  = byte_q;
    assign dp.tx_data      = sel_q ? ch1_rd_data : ch0_rd_data;
    assign busy            = (state_q != IDLE);
    assign timeout_err     = terr_q;
    assign frame_cnt       = fcnt_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Bench for udp_tx_sched: timestamp-based frame model checked every cycle plus directed scenarios.
module tb_udp_tx_sched;

    localparam int SH  = 4;
    localparam int IFG = 16;
    localparam int TMO = 100;
    localparam int MAXB = 1472;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ch0_req, ch1_req;
    logic [15:0] ch0_byte_num, ch1_byte_num;
    logic        ch0_grant, ch1_grant, ch0_rd_en, ch1_rd_en, ch0_done, ch1_done;
    logic [7:0]  ch0_rd_data, ch1_rd_data;
    logic        busy, timeout_err;
    logic [15:0] frame_cnt;

    udp_tx_sched_if dp ();

    udp_tx_sched #(
        .START_HOLD(SH), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO), .MAX_BYTES(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_grant(ch0_grant),
        .ch0_rd_en(ch0_rd_en), .ch0_rd_data(ch0_rd_data), .ch0_done(ch0_done),
        .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_grant(ch1_grant),
        .ch1_rd_en(ch1_rd_en), .ch1_rd_data(ch1_rd_data), .ch1_done(ch1_done),
        .dp(dp), .busy(busy), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: frame described by timestamps (edge indices), not by states.
    int          cyc = 0;
    bit          m_act;
    int          m_n0, m_fd, m_idle, m_dedge;
    bit          m_sel, m_last, m_dsel, m_tmo;
    logic [15:0] m_bytes, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_n0 = 0; m_fd = -1; m_idle = 0; m_dedge = -100;
            m_sel = 0; m_last = 1; m_dsel = 0; m_tmo = 0; m_bytes = 0; m_cnt = 0;
        end else begin
            cyc++;
            if (m_act) begin
                if (dp.tx_done && m_fd < 0) m_fd = cyc;
                if ((m_fd >= 0 && cyc >= m_n0 + SH + 1) || cyc == m_n0 + TMO) begin
                    m_tmo   = !(m_fd >= 0 && cyc >= m_n0 + SH + 1);
                    if (!m_tmo) m_cnt = m_cnt + 16'd1;
                    m_act   = 0;
                    m_dedge = cyc;
                    m_dsel  = m_sel;
                    m_idle  = cyc + IFG + 1;
                end
            end else if (cyc >= m_idle && (ch0_req || ch1_req)) begin
                logic [15:0] b;
                m_sel   = (ch0_req && ch1_req) ? !m_last : ch1_req;
                m_last  = m_sel;
                b       = m_sel ? ch1_byte_num : ch0_byte_num;
                m_bytes = (b > 16'(MAXB)) ? 16'(MAXB) : b;
                if (b == 16'd0) begin
                    m_dedge = cyc; m_dsel = m_sel; m_tmo = 0;
                    m_idle  = cyc + IFG + 1;
                end else begin
                    m_act = 1; m_n0 = cyc; m_fd = -1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    int strobe_cnt, rd0_cnt, rd1_cnt, done0_cnt, done1_cnt, g1_cnt;
    bit stim_done = 0;

    task automatic clear_counts();
        strobe_cnt = 0; rd0_cnt = 0; rd1_cnt = 0; done0_cnt = 0; done1_cnt = 0; g1_cnt = 0;
    endtask

    task automatic compare_cycle();
        bit e_g0, e_g1;
        e_g0 = m_act && !m_sel;
        e_g1 = m_act && m_sel;
        check("strobe", dp.tx_start_en, m_act && (cyc < m_n0 + SH));
        check("state_change", dp.state_change, m_act && (cyc < m_n0 + SH));
        check("ch0_grant", ch0_grant, e_g0);
        check("ch1_grant", ch1_grant, e_g1);
        check("busy", busy, m_act || (cyc < m_idle - 1));
        check("ch0_done", ch0_done, (m_dedge == cyc) && !m_dsel);
        check("ch1_done", ch1_done, (m_dedge == cyc) && m_dsel);
        check("timeout_err", timeout_err, (m_dedge == cyc) && m_tmo);
        check("frame_cnt", frame_cnt, m_cnt);
        check("tx_byte_num", dp.tx_byte_num, m_bytes);
        check("ch0_rd_en", ch0_rd_en, dp.tx_req && e_g0);
        check("ch1_rd_en", ch1_rd_en, dp.tx_req && e_g1);
        check("tx_data", dp.tx_data, m_sel ? ch1_rd_data : ch0_rd_data);
        strobe_cnt += int'(dp.tx_start_en);
        rd0_cnt    += int'(ch0_rd_en);
        rd1_cnt    += int'(ch1_rd_en);
        done0_cnt  += int'(ch0_done);
        done1_cnt  += int'(ch1_done);
        g1_cnt     += int'(ch1_grant);
    endtask

    // which: 0 strobe high, 1 idle, 2 ch1_done, 3 timeout_err
    task automatic wait_cond(input int which, input string name, input int budget);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            case (which)
                0:       hit = dp.tx_start_en;
                1:       hit = !busy;
                2:       hit = ch1_done;
                default: hit = timeout_err;
            endcase
            if (hit) break;
            @(posedge clk); #1;
        end
        if (!hit) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: condition still false after %0d cycles, required true", name, budget);
        end
    endtask

    task automatic run_frame(input int nb, input bit give_done);
        for (int i = 0; i < 8 && dp.tx_start_en; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < nb; i++) begin
            dp.tx_req   = 1'b1;
            ch0_rd_data = 8'(i * 3 + 1);
            ch1_rd_data = 8'(~i);
            @(posedge clk); #1;
        end
        dp.tx_req = 1'b0;
        if (give_done) begin
            dp.tx_done = 1'b1;
            @(posedge clk); #1;
            dp.tx_done = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ch0_req = 0; ch1_req = 0; ch0_byte_num = 0; ch1_byte_num = 0;
        ch0_rd_data = 8'h11; ch1_rd_data = 8'h22;
        dp.tx_req = 0; dp.tx_done = 0;
        clear_counts();
        fork
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    if (!stim_done) compare_cycle();
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
                check("rst_busy", busy, 0);
                check("rst_frame_cnt", frame_cnt, 0);
                check("rst_grants", {ch1_grant, ch0_grant}, 0);
                check("rst_strobe", dp.tx_start_en, 0);

                // single ch0 frame of 32 bytes
                clear_counts();
                ch0_byte_num = 16'd32; ch0_req = 1;
                wait_cond(0, "t1_strobe", 20);
                ch0_req = 0;
                run_frame(32, 1);
                wait_cond(1, "t1_idle", 60);
                check("t1_strobe_cycles", strobe_cnt, 4);
                check("t1_rd0_cycles", rd0_cnt, 32);
                check("t1_rd1_cycles", rd1_cnt, 0);
                check("t1_done0_pulses", done0_cnt, 1);
                check("t1_frame_cnt", frame_cnt, 1);

                // contention from reset: alternating grants and inter-frame gap
                do_reset();
                ch0_byte_num = 16'd20; ch1_byte_num = 16'd20;
                ch0_req = 1; ch1_req = 1;
                for (int k = 0; k < 4; k++) begin
                    int gap;
                    wait_cond(0, "t2_strobe", 60);
                    check($sformatf("t2_grant1_frame%0d", k), ch1_grant, 32'(k & 1));
                    if (k == 3) begin ch0_req = 0; ch1_req = 0; end
                    run_frame(20, 1);
                    if (k < 3) begin
                        gap = 0;
                        while (!dp.tx_start_en && gap < 60) begin @(posedge clk); #1; gap++; end
                        check($sformatf("t2_gap_ge_ifg_%0d", k), gap >= IFG, 1);
                    end
                end
                wait_cond(1, "t2_idle", 60);
                check("t2_frame_cnt", frame_cnt, 4);

                // clamped length, then zero-length request
                ch1_byte_num = 16'd2000; ch1_req = 1;
                wait_cond(0, "t3_strobe", 20);
                ch1_req = 0;
                check("t3_clamp", dp.tx_byte_num, 1472);
                run_frame(20, 1);
                wait_cond(1, "t3_idle", 60);
                clear_counts();
                ch1_byte_num = 16'd0; ch1_req = 1;
                wait_cond(2, "t3_zero_done", 20);
                ch1_req = 0;
                wait_cond(1, "t3_zero_idle", 60);
                check("t3_zero_strobes", strobe_cnt, 0);
                check("t3_zero_grant", g1_cnt, 0);
                check("t3_zero_done1", done1_cnt, 1);
                check("t3_zero_frame_cnt", frame_cnt, 5);

                // timeout: no tx_done ever returned
                begin
                    int t0;
                    ch0_byte_num = 16'd10; ch0_req = 1;
                    wait_cond(0, "t4_strobe", 20);
                    ch0_req = 0;
                    t0 = cyc;
                    run_frame(10, 0);
                    wait_cond(3, "t4_timeout", 200);
                    check("t4_timeout_delay", cyc - t0, 100);
                    check("t4_done0_with_timeout", ch0_done, 1);
                    check("t4_grant_dropped", ch0_grant, 0);
                    wait_cond(1, "t4_idle", 60);
                    check("t4_frame_cnt", frame_cnt, 5);
                    ch1_byte_num = 16'd8; ch1_req = 1;
                    wait_cond(0, "t4_next_strobe", 20);
                    ch1_req = 0;
                    check("t4_next_grant1", ch1_grant, 1);
                    run_frame(8, 1);
                    wait_cond(1, "t4_next_idle", 60);
                    check("t4_next_frame_cnt", frame_cnt, 6);
                end

                // reset in the middle of BUSY
                ch0_byte_num = 16'd40; ch0_req = 1;
                wait_cond(0, "t5_strobe", 20);
                ch0_req = 0;
                for (int i = 0; i < 8 && dp.tx_start_en; i++) begin @(posedge clk); #1; end
                dp.tx_req = 1'b1;
                repeat (10) begin @(posedge clk); #1; end
                #2 rst_n = 1'b0;
                #1;
                check("t5_rst_busy", busy, 0);
                check("t5_rst_grant0", ch0_grant, 0);
                check("t5_rst_rd0", ch0_rd_en, 0);
                check("t5_rst_strobes", {dp.tx_start_en, dp.state_change}, 0);
                check("t5_rst_done0", ch0_done, 0);
                check("t5_rst_frame_cnt", frame_cnt, 0);
                dp.tx_req = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                @(posedge clk); #1;
                check("t5_post_busy", busy, 0);
                ch0_byte_num = 16'd12; ch1_byte_num = 16'd12;
                ch0_req = 1; ch1_req = 1;
                wait_cond(0, "t5_strobe2", 20);
                check("t5_ch0_wins", ch0_grant, 1);
                ch0_req = 0; ch1_req = 0;
                run_frame(12, 1);
                wait_cond(1, "t5_idle", 60);
                check("t5_frame_cnt", frame_cnt, 1);

                // spurious datapath activity while idle
                clear_counts();
                dp.tx_req = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
                dp.tx_done = 1'b1;
                @(posedge clk); #1;
                dp.tx_done = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                dp.tx_req = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                check("t6_rd_cycles", rd0_cnt + rd1_cnt, 0);
                check("t6_done_pulses", done0_cnt + done1_cnt, 0);
                check("t6_frame_cnt", frame_cnt, 1);

                stim_done = 1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Frame scheduler in front of the UDP transmit datapath (udp_tx). It shares that datapath between two packet sources (e.g. ADC sample buffer and measurement-result buffer).
- Arbitrates round-robin, latches the winner's byte count, and generates the start strobes (tx_start_en and state_change).
- Steers the datapath's tx_req to the granted source's FIFO read port and muxes its data back.
- Waits for tx_done, or a timeout, then enforces an inter-frame gap before the next grant.

Parameters:
- START_HOLD, 4, cycles tx_start_en/state_change are held high per frame (>=3 so the datapath's 3-flop edge detectors capture it).
- IFG_CYCLES, 16, minimum idle cycles between tx_done and the next start strobe.
- TIMEOUT_CYCLES, 65535, cycles allowed in BUSY before the frame is abandoned.
- MAX_BYTES, 1472, maximum UDP payload; larger requests are clamped.

Ports:
- clk  in  1  system clock (GMII tx clock domain).
- rst_n  in  1  asynchronous active-low reset.
- ch0_req  in  1  level request: ch0 has a frame ready.
- ch0_byte_num  in  16  ch0 payload bytes; sampled at grant.
- ch0_grant  out  1  ch0 owns the datapath.
- ch0_rd_en  out  1  ch0 FIFO read strobe.
- ch0_rd_data  in  8  ch0 FIFO read data.
- ch0_done  out  1  one-cycle pulse: ch0 frame finished or aborted.
- ch1_req, ch1_byte_num, ch1_grant, ch1_rd_en, ch1_rd_data, ch1_done: same as ch0, for source 1.
- tx_start_en  out  1  start strobe to datapath (byte-count latch).
- state_change  out  1  start strobe to datapath (FSM launch); identical to tx_start_en.
- tx_byte_num  out  16  payload length to datapath.
- tx_data  out  8  payload byte to datapath.
- tx_req  in  1  datapath read request.
- tx_done  in  1  datapath one-cycle frame-complete pulse.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  one-cycle pulse when a frame is abandoned.
- frame_cnt  out  16  count of frames completed by tx_done; wraps 0xFFFF->0.

Behaviour:
- Reset: clk single clock; rst_n asynchronous active-low. All outputs 0, FSM=IDLE, last_served=1 (so ch0 wins the first contention), counters 0. Asserting rst_n mid-frame drops the grant, strobes and rd_en immediately; no done pulse is issued.
- FSM states: IDLE, START, BUSY, GAP (one-hot).
- IDLE:
  - If exactly one req is high, select it.
  - If both are high, select the channel != last_served.
  - On select: register sel; grant=1 next cycle; tx_byte_num = min(byte_num, MAX_BYTES); last_served=sel; go to START.
  - If the selected byte_num==0: no frame is sent. chX_done pulses one cycle, grant is not asserted, go to GAP.
- START: tx_start_en=state_change=1 for exactly START_HOLD cycles (counter), then both drop to 0 and the FSM moves to BUSY. tx_byte_num is held stable from entry to START until exit from BUSY.
- BUSY:
  - Wait for tx_done. A tx_done arriving in START is latched and honoured on BUSY entry.
  - On tx_done: chX_done pulses 1 cycle, frame_cnt+1, grant drops, go to GAP.
  - Timeout counter starts at 0 on START entry and counts through START and BUSY. At TIMEOUT_CYCLES: timeout_err and chX_done pulse 1 cycle, frame_cnt unchanged, grant drops, go to GAP.
- GAP: counts IFG_CYCLES cycles with all strobes low, then goes to IDLE. Requests arriving during GAP wait.
- Data path (combinational on registered sel):
  - chX_rd_en = tx_req & chX_grant.
  - tx_data = ch0_rd_data if sel==0, else ch1_rd_data.
  - rd_en is never high for a non-granted channel, nor in IDLE/GAP.
- tx_req or tx_done seen in IDLE/GAP is ignored: no rd_en, no done pulse.
- Clamping: when byte_num > MAX_BYTES, the source FIFO retains the excess bytes. The requester is responsible for flushing them.
- req is level: if still high after chX_done it is a new request, arbitrated after GAP. Round-robin then alternates when both are pending.
- frame_cnt is 16-bit unsigned with silent wrap.

Test Plan:
- Single ch0 request, byte_num=32; bench model raises tx_req for 32 cycles then pulses tx_done -> strobes high exactly 4 cycles; ch0_rd_en==tx_req for 32 cycles; ch0_done 1 pulse; frame_cnt=1; no ch1_rd_en.
- ch0_req and ch1_req high together from reset, byte_num=20 each, reqs held -> grants in order ch0, ch1, ch0, ch1; >=16 low cycles between tx_done and the next strobe rise.
- ch1 byte_num=2000 -> tx_byte_num=1472 during the frame; byte_num=0 -> ch1_done pulse, no strobe, no grant, frame_cnt unchanged.
- Model never returns tx_done, TIMEOUT_CYCLES=100 -> timeout_err and ch0_done pulse 100 cycles after START entry; grant drops; frame_cnt unchanged; next request served normally.
- rst_n asserted mid-BUSY (after 10 tx_req cycles) -> all outputs 0 asynchronously; after release busy=0 and ch0 wins the next contention.
- Spurious tx_req/tx_done in IDLE -> no rd_en, no done, frame_cnt unchanged.
